cam_capture_sequencer: RTL

//  Single-clock controller that sequences the OV7670 path: power-up delay, SCCB config

---
 rtl/cam_capture_sequencer_if.sv | 36 +++
 rtl/cam_capture_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/cam_capture_sequencer_if.sv
// Camera sequencer bundle: config handshake, vsync/pixel stream in, framebuffer write port out.
// Latency: none (wires only).
// Backpressure: none; pixel stream and write strobes are fire-and-forget.
//
// Ports (master = environment side, slave = sequencer side):
//   cfg_done, vsync, pix_valid, pix_data[15:0], snap_req, cont_mode   master -> slave
//   cfg_start, wr_en, wr_addr[ADDR_W-1:0], wr_data[15:0],
//   frame_ready, busy, err, frame_count[15:0]                         slave -> master
interface cam_capture_sequencer_if #(
  parameter int ADDR_W = 17
);
  logic              cfg_done;
  logic              vsync;
  logic              pix_valid;
  logic [15:0]       pix_data;
  logic              snap_req;
  logic              cont_mode;
  logic              cfg_start;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              frame_ready;
  logic              busy;
  logic              err;
  logic [15:0]       frame_count;

  modport master (
    output cfg_done, vsync, pix_valid, pix_data, snap_req, cont_mode,
    input  cfg_start, wr_en, wr_addr, wr_data, frame_ready, busy, err, frame_count
  );

  modport slave (
    input  cfg_done, vsync, pix_valid, pix_data, snap_req, cont_mode,
    output cfg_start, wr_en, wr_addr, wr_data, frame_ready, busy, err, frame_count
  );
endinterface

// File: rtl/cam_capture_sequencer.sv
// OV7670 path sequencer: power-up wait, config kick, settle-frame skip, frame capture into RAM writes.
// Latency: pixel -> write strobe 1 cycle; vsync -> frame boundary 3 cycles (2-flop sync + edge detect).
// Backpressure: none; pixels beyond the frame size are dropped and flag err.
//
// Ports: i_clk25 (clock, also camera XCLK), i_rst (synchronous, active high),
//        io_seq (cam_capture_sequencer_if.slave): config handshake, vsync/pixel input,
//        framebuffer write port, frame_ready/busy/err status, frame_count.
// Optional feature macro: CAM_SEQ_STATS_EN -- live frame_count plus latched err cause;
//        when undefined frame_count reads 16'h0.
// Parameters must satisfy PWRUP_CYCLES >= 1, CFG_TIMEOUT >= 1, FRAME_PIXELS <= 2**ADDR_W.
module cam_capture_sequencer #(
  parameter int PWRUP_CYCLES = 1000,
  parameter int CFG_TIMEOUT  = 2000000,
  parameter int SKIP_FRAMES  = 2,
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 17
) (
  input  logic                     i_clk25,
  input  logic                     i_rst,
  cam_capture_sequencer_if.slave   io_seq
);

  localparam logic [3:0] S_RESET_WAIT = 4'd0;
  localparam logic [3:0] S_CFG_PULSE  = 4'd1;
  localparam logic [3:0] S_CFG_WAIT   = 4'd2;
  localparam logic [3:0] S_SETTLE     = 4'd3;
  localparam logic [3:0] S_IDLE       = 4'd4;
  localparam logic [3:0] S_ARM        = 4'd5;
  localparam logic [3:0] S_CAPTURE    = 4'd6;
  localparam logic [3:0] S_DONE       = 4'd7;
  localparam logic [3:0] S_ERROR      = 4'd8;

  localparam logic [31:0]     L_PWRUP_LAST   = 32'(PWRUP_CYCLES - 1);
  localparam logic [31:0]     L_TIMEOUT_LAST = 32'(CFG_TIMEOUT - 1);
  localparam logic [31:0]     L_SKIP_LAST    = 32'(SKIP_FRAMES - 1);
  // One extra bit so the address counter can sit at FRAME_PIXELS (the "full" marker).
  localparam logic [ADDR_W:0] L_FRAME_PIX    = (ADDR_W + 1)'(FRAME_PIXELS);

  logic [3:0]        r_state;
  logic [31:0]       r_cnt;      // shared by power-up, config timeout and settle-frame counting
  logic [ADDR_W:0]   r_addr;
  logic              r_vs_s1;
  logic              r_vs_s2;
  logic              r_vs_s3;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [15:0]       r_wr_data;
  logic              r_err;

  logic w_vs_rise;
  logic w_pix_ok;
  logic w_pix_ovf;
  logic w_cfg_timeout;

  assign w_vs_rise     = r_vs_s2 & ~r_vs_s3;
  assign w_pix_ok      = (r_state == S_CAPTURE) && io_seq.pix_valid && (r_addr < L_FRAME_PIX);
  assign w_pix_ovf     = (r_state == S_CAPTURE) && io_seq.pix_valid && (r_addr >= L_FRAME_PIX);
  assign w_cfg_timeout = (r_state == S_CFG_WAIT) && !io_seq.cfg_done && (r_cnt == L_TIMEOUT_LAST);

  // vsync comes from the sensor pad: two flops for metastability, third for edge detect.
  always_ff @(posedge i_clk25) begin
    if (i_rst) begin
      r_vs_s1 <= 1'b0;
      r_vs_s2 <= 1'b0;
      r_vs_s3 <= 1'b0;
    end else begin
      r_vs_s1 <= io_seq.vsync;
      r_vs_s2 <= r_vs_s1;
      r_vs_s3 <= r_vs_s2;
    end
  end

  always_ff @(posedge i_clk25) begin
    if (i_rst) begin
      r_state   <= S_RESET_WAIT;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      // A pixel arriving together with the closing vsync edge is still written.
      if (w_pix_ok) begin
        r_wr_en   <= 1'b1;
        r_wr_addr <= r_addr[ADDR_W-1:0];
        r_wr_data <= io_seq.pix_data;
        r_addr    <= r_addr + 1'b1;
      end
      if (w_pix_ovf || w_cfg_timeout) begin
        r_err <= 1'b1;
      end

      case (r_state)
        S_RESET_WAIT: begin
          if (r_cnt == L_PWRUP_LAST) begin
            r_state <= S_CFG_PULSE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CFG_PULSE: begin
          r_state <= S_CFG_WAIT;
          r_cnt   <= '0;
        end
        S_CFG_WAIT: begin
          if (io_seq.cfg_done) begin
            r_state <= (SKIP_FRAMES == 0) ? S_IDLE : S_SETTLE;
            r_cnt   <= '0;
          end else if (w_cfg_timeout) begin
            r_state <= S_ERROR;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          if (w_vs_rise) begin
            if (r_cnt == L_SKIP_LAST) begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
        end
        S_IDLE: begin
          if (io_seq.snap_req || io_seq.cont_mode) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (w_vs_rise) begin
            r_state <= S_CAPTURE;
            r_addr  <= '0;
          end
        end
        S_CAPTURE: begin
          if (w_vs_rise) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= io_seq.cont_mode ? S_ARM : S_IDLE;
        end
        S_ERROR: begin
          r_state <= S_ERROR;
        end
        default: begin
          r_state <= S_ERROR;
        end
      endcase
    end
  end

`ifdef CAM_SEQ_STATS_EN
  logic [15:0] r_frame_count;
  logic [1:0]  r_err_cause;  // [0] config timeout, [1] pixel overflow; probe-only

  always_ff @(posedge i_clk25) begin
    if (i_rst) begin
      r_frame_count <= '0;
      r_err_cause   <= '0;
    end else begin
      if (r_state == S_DONE) begin
        r_frame_count <= r_frame_count + 16'd1;
      end
      if (w_cfg_timeout) begin
        r_err_cause[0] <= 1'b1;
      end
      if (w_pix_ovf) begin
        r_err_cause[1] <= 1'b1;
      end
    end
  end

  assign io_seq.frame_count = r_frame_count;
`else
  assign io_seq.frame_count = 16'h0;
`endif

  assign io_seq.cfg_start   = (r_state == S_CFG_PULSE);
  assign io_seq.frame_ready = (r_state == S_DONE);
  assign io_seq.busy        = (r_state != S_IDLE);
  assign io_seq.wr_en       = r_wr_en;
  assign io_seq.wr_addr     = r_wr_addr;
  assign io_seq.wr_data     = r_wr_data;
  assign io_seq.err         = r_err;

endmodule
